// File: rtl/cur_block_buffer_if.sv
// Fetch and row-stream signals of the current-block buffer.
// The slave modport is the buffer; the master modport is its environment.
interface cur_block_buffer_if #(parameter int BLK_W = 16);
  logic [63:0]        cur_in;
  logic               cur_valid;
  logic               cur_req;
  logic [31:0]        cur_mem_addr;
  logic [BLK_W*8-1:0] cur_row;
  logic [3:0]         cur_row_idx;
  logic               cur_row_valid;

  modport slave  (input  cur_in, cur_valid,
                  output cur_req, cur_mem_addr, cur_row, cur_row_idx, cur_row_valid);
  modport master (output cur_in, cur_valid,
                  input  cur_req, cur_mem_addr, cur_row, cur_row_idx, cur_row_valid);
endinterface

// File: rtl/cur_block_buffer.sv
// Ping-pong staging buffer for the current macroblock: fills one bank from memory,
// and on each next_block pulse swaps banks and streams the filled one row by row.
//
// state    | meaning
// S_IDLE   | no rows being emitted; last row held on cur_row
// S_STREAM | emitting one read-bank row per enabled cycle
module cur_block_buffer #(
  parameter int BLK_W = 16,
  parameter int BLK_H = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             next_block,
  cur_block_buffer_if.slave bus,
  output logic             block_ready,
  output logic             underrun,
  output logic [9:0]       blk_cnt
);
  localparam int WPR    = BLK_W / 8;
  localparam int NWORDS = BLK_H * WPR;
  localparam int PW     = $clog2(NWORDS);
  localparam int RW     = BLK_W * 8;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            fill_full_q, fill_full_d;
  logic            rd_sel_q, rd_sel_d;
  logic [31:0]     addr_q, addr_d;
  logic [RW-1:0]   row_q, row_d;
  logic [3:0]      idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            ready_q, ready_d;
  logic            under_q, under_d;
  logic [9:0]      blk_q, blk_d;

  logic [63:0]     bank_q [2][NWORDS];

  logic            wr_en, last_wr, complete, swap;
  logic [3:0]      nxt_row;
  logic            nxt_bank;
  logic [PW-1:0]   widx;
  logic [RW-1:0]   row_pick;

  assign wr_en    = en & bus.cur_valid & ~fill_full_q;
  assign last_wr  = wr_en & (wr_ptr_q == PW'(NWORDS - 1));
  assign complete = fill_full_q | last_wr;
  assign swap     = en & next_block & complete;

  // On a swap the bank being filled becomes the read bank, so row 0 comes from it.
  always_comb begin
    nxt_row  = swap ? 4'd0 : 4'(idx_q + 4'd1);
    nxt_bank = swap ? ~rd_sel_q : rd_sel_q;
    row_pick = '0;
    widx     = '0;
    for (int w = 0; w < WPR; w++) begin
      widx = PW'(int'(nxt_row) * WPR + w);
      row_pick[RW-1-64*w -: 64] = bank_q[nxt_bank][widx];
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_full_d = fill_full_q;
    rd_sel_d    = rd_sel_q;
    addr_d      = addr_q;
    row_d       = row_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    ready_d     = ready_q;
    under_d     = under_q;
    blk_d       = blk_q;
    if (en) begin
      if (wr_en) begin
        addr_d   = addr_q + 32'd8;
        wr_ptr_d = last_wr ? '0 : PW'(wr_ptr_q + 1'b1);
        if (last_wr) fill_full_d = 1'b1;
      end
      case (state_q)
        S_STREAM: begin
          if (idx_q == 4'(BLK_H - 1)) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
          end else begin
            idx_d = nxt_row;
            row_d = row_pick;
          end
        end
        default: ;
      endcase
      if (next_block) begin
        if (complete) begin
          rd_sel_d    = ~rd_sel_q;
          fill_full_d = 1'b0;
          blk_d       = blk_q + 10'd1;
          ready_d     = 1'b1;
          state_d     = S_STREAM;
          idx_d       = 4'd0;
          valid_d     = 1'b1;
          row_d       = row_pick;
        end else begin
          under_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      fill_full_q <= 1'b0;
      rd_sel_q    <= 1'b0;
      addr_q      <= '0;
      row_q       <= '0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b0;
      under_q     <= 1'b0;
      blk_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_full_q <= fill_full_d;
      rd_sel_q    <= rd_sel_d;
      addr_q      <= addr_d;
      row_q       <= row_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
      under_q     <= under_d;
      blk_q       <= blk_d;
    end
  end

  // Bank contents need no reset; the write uses the pre-swap fill bank.
  always_ff @(posedge clk) begin
    if (wr_en) bank_q[~rd_sel_q][wr_ptr_q] <= bus.cur_in;
  end

  assign bus.cur_req       = en & rst & ~fill_full_q;
  assign bus.cur_mem_addr  = addr_q;
  assign bus.cur_row       = row_q;
  assign bus.cur_row_idx   = idx_q;
  assign bus.cur_row_valid = valid_q & en;
  assign block_ready       = ready_q;
  assign underrun          = under_q;
  assign blk_cnt           = blk_q;
endmodule
